// File: rtl/seq_pkg.sv
// Shared types and pattern constants for the thermometer sequencer (sequenciador_vetor).
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int E_WIDTH = 4;

  localparam logic [E_WIDTH-1:0] E_0000 = 4'b0000;
  localparam logic [E_WIDTH-1:0] E_1000 = 4'b1000;
  localparam logic [E_WIDTH-1:0] E_1100 = 4'b1100;
  localparam logic [E_WIDTH-1:0] E_1110 = 4'b1110;

endpackage

// File: rtl/divisor_tick.sv
// Prescaler: counts 0..DIV-1 while enabled and emits a one-cycle tick on the terminal count.
module divisor_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] count;

  assign tick = en && (count == CW'(DIV - 1));

  // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sequenciador_vetor.sv
// Timed thermometer sequencer driving the 4-bit E bus of the display decoder.
// Optional macro SEQ_LOOP_EN: completed sequences restart in FILL instead of returning to IDLE.
module sequenciador_vetor
  import seq_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int STEPS      = 3,
  parameter int HOLD_TICKS = 2
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic               start,
  input  logic               pause,
  output logic [E_WIDTH-1:0] E,
  output logic               busy,
  output logic               done
);

  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  state_t             state_q, state_d;
  logic [E_WIDTH-1:0] e_q, e_d, fill_next;
  logic [HW-1:0]      hold_q, hold_d;
  logic               done_q, done_d;
  logic               tick, presc_en, presc_clr;

  assign presc_en  = (state_q != IDLE) && !pause;
  assign presc_clr = (state_q == IDLE) && start;

  divisor_tick #(.DIV(TICK_DIV)) u_divisor_tick (
    .clk  (CLOCK_50),
    .rst  (RESET),
    .clr  (presc_clr),
    .en   (presc_en),
    .tick (tick)
  );

  assign fill_next = {1'b1, e_q[E_WIDTH-1:1]};

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        e_d = E_0000;
        if (start) state_d = FILL;
      end
      FILL: begin
        if (tick) begin
          e_d = fill_next;
          // Thermometer fill: bit E_WIDTH-STEPS set means STEPS ones are present.
          if (fill_next[E_WIDTH-STEPS]) begin
            state_d = HOLD;
            hold_d  = '0;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          if (hold_q == HW'(HOLD_TICKS - 1)) begin
            e_d    = E_0000;
            done_d = 1'b1;
            hold_d = '0;
`ifdef SEQ_LOOP_EN
            state_d = FILL;
`else
            state_d = IDLE;
`endif
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        e_d     = E_0000;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= IDLE;
      e_q     <= E_0000;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  assign E    = e_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule
